// File: rtl/lcd_refresh_ctrl.sv
// lcd_refresh_ctrl
// ----------------
// Drives a 16x2 HD44780-compatible character LCD in 8-bit write-only mode.
// After reset it waits out the panel power-up time, sends the initialisation
// command list, and then refreshes both rows continuously from shadow copies
// of the game engine's line buffers, with an idle gap between frames.
//
// Ports:
//   clk_in         in   1   system clock
//   rst_in         in   1   synchronous active-high reset
//   line1_in       in 128   top row, [127:120] = column 0 ... [7:0] = column 15
//   line2_in       in 128   bottom row, same byte order
//   freeze_in      in   1   when high at the end of the frame gap, hold off the next frame
//   lcd_rs_out     out  1   0 = command, 1 = data
//   lcd_rw_out     out  1   always 0 (write only)
//   lcd_e_out      out  1   enable strobe
//   lcd_db_out     out  8   data bus
//   init_done_out  out  1   high once the clear-display gap has elapsed
//   frame_done_out out  1   one-cycle pulse after the last byte of each frame
module lcd_refresh_ctrl #(
  parameter int E_HIGH    = 12,
  parameter int CMD_GAP   = 2500,
  parameter int CLEAR_GAP = 100000,
  parameter int PWR_WAIT  = 1000000,
  parameter int FRAME_GAP = 50000
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [127:0] line1_in,
  input  logic [127:0] line2_in,
  input  logic         freeze_in,
  output logic         lcd_rs_out,
  output logic         lcd_rw_out,
  output logic         lcd_e_out,
  output logic [7:0]   lcd_db_out,
  output logic         init_done_out,
  output logic         frame_done_out
);

  // The shared counter is loaded with N-1 and a phase ends in the cycle it reads zero.
  localparam logic [23:0] E_HIGH_M1    = 24'(E_HIGH - 1);
  localparam logic [23:0] CMD_GAP_M1   = 24'(CMD_GAP - 1);
  localparam logic [23:0] CLEAR_GAP_M1 = 24'(CLEAR_GAP - 1);
  localparam logic [23:0] PWR_WAIT_M1  = 24'(PWR_WAIT - 1);
  localparam logic [23:0] FRAME_GAP_M1 = 24'(FRAME_GAP - 1);

  typedef enum logic [2:0] {
    ST_PWR   = 3'd0,
    ST_INIT  = 3'd1,
    ST_SNAP  = 3'd2,
    ST_ADDR1 = 3'd3,
    ST_DATA1 = 3'd4,
    ST_ADDR2 = 3'd5,
    ST_DATA2 = 3'd6,
    ST_GAP   = 3'd7
  } top_state_t;

  typedef enum logic [1:0] {
    BW_IDLE  = 2'd0,
    BW_SETUP = 2'd1,
    BW_EHI   = 2'd2,
    BW_HOLD  = 2'd3
  } bw_state_t;

  top_state_t    state_r, state_s;
  bw_state_t     bw_r, bw_s;
  logic [23:0]   cnt_r, cnt_s;
  logic [2:0]    idx_r, idx_s;
  logic [3:0]    col_r, col_s;
  logic          rs_r, rs_s;
  logic [7:0]    db_r, db_s;
  logic          e_r, e_s;
  logic          init_done_r, init_done_s;
  logic          frame_done_r, frame_done_s;
  logic [127:0]  shadow1_r, shadow2_r;
  logic          snap_s;
  logic          start_s;
  logic          start_rs_s;
  logic [7:0]    start_db_s;
  logic          byte_done_s;
  logic          is_clear_s;

  // Initialisation command list: 8-bit/2-line x3, display on, entry mode, clear.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h38;
      3'd1:    return 8'h38;
      3'd2:    return 8'h38;
      3'd3:    return 8'h0C;
      3'd4:    return 8'h06;
      3'd5:    return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  // Column 0 lives in the top byte of the row vector.
  function automatic logic [7:0] col_byte(input logic [127:0] line, input logic [3:0] col);
    logic [6:0] base;
    base = {4'd15 - col, 3'b000};
    return line[base +: 8];
  endfunction

  assign byte_done_s = (bw_r == BW_HOLD) && (cnt_r == 24'd0);
  // Only the clear command needs the long settle time; a data byte of 0x01 does not.
  assign is_clear_s  = (rs_r == 1'b0) && (db_r == 8'h01);

  // Next-state logic for the byte writer and the top-level sequencer.
  always_comb begin
    state_s      = state_r;
    bw_s         = bw_r;
    cnt_s        = cnt_r;
    idx_s        = idx_r;
    col_s        = col_r;
    rs_s         = rs_r;
    db_s         = db_r;
    e_s          = 1'b0;
    init_done_s  = init_done_r;
    frame_done_s = 1'b0;
    snap_s       = 1'b0;
    start_s      = 1'b0;
    start_rs_s   = 1'b0;
    start_db_s   = 8'h00;

    case (bw_r)
      BW_IDLE: begin
        bw_s = BW_IDLE;
      end
      BW_SETUP: begin
        bw_s  = BW_EHI;
        cnt_s = E_HIGH_M1;
      end
      BW_EHI: begin
        if (cnt_r == 24'd0) begin
          bw_s = BW_HOLD;
          if (is_clear_s) begin
            cnt_s = CLEAR_GAP_M1;
          end else begin
            cnt_s = CMD_GAP_M1;
          end
        end else begin
          cnt_s = cnt_r - 24'd1;
        end
      end
      BW_HOLD: begin
        if (cnt_r == 24'd0) begin
          bw_s = BW_IDLE;
        end else begin
          cnt_s = cnt_r - 24'd1;
        end
      end
      default: begin
        bw_s = BW_IDLE;
      end
    endcase

    // A new byte always starts in the cycle right after the previous HOLD,
    // so consecutive bytes are back to back.
    case (state_r)
      ST_PWR: begin
        if (cnt_r == 24'd0) begin
          state_s    = ST_INIT;
          idx_s      = 3'd0;
          start_s    = 1'b1;
          start_rs_s = 1'b0;
          start_db_s = init_cmd(3'd0);
        end else begin
          cnt_s = cnt_r - 24'd1;
        end
      end
      ST_INIT: begin
        if (byte_done_s) begin
          if (idx_r == 3'd5) begin
            state_s     = ST_SNAP;
            init_done_s = 1'b1;
          end else begin
            idx_s      = idx_r + 3'd1;
            start_s    = 1'b1;
            start_rs_s = 1'b0;
            start_db_s = init_cmd(idx_r + 3'd1);
          end
        end else begin
          state_s = ST_INIT;
        end
      end
      ST_SNAP: begin
        snap_s     = 1'b1;
        state_s    = ST_ADDR1;
        start_s    = 1'b1;
        start_rs_s = 1'b0;
        start_db_s = 8'h80;
      end
      ST_ADDR1: begin
        if (byte_done_s) begin
          state_s    = ST_DATA1;
          col_s      = 4'd0;
          start_s    = 1'b1;
          start_rs_s = 1'b1;
          start_db_s = col_byte(shadow1_r, 4'd0);
        end else begin
          state_s = ST_ADDR1;
        end
      end
      ST_DATA1: begin
        if (byte_done_s) begin
          if (col_r == 4'd15) begin
            state_s    = ST_ADDR2;
            col_s      = 4'd0;
            start_s    = 1'b1;
            start_rs_s = 1'b0;
            start_db_s = 8'hC0;
          end else begin
            col_s      = col_r + 4'd1;
            start_s    = 1'b1;
            start_rs_s = 1'b1;
            start_db_s = col_byte(shadow1_r, col_r + 4'd1);
          end
        end else begin
          state_s = ST_DATA1;
        end
      end
      ST_ADDR2: begin
        if (byte_done_s) begin
          state_s    = ST_DATA2;
          col_s      = 4'd0;
          start_s    = 1'b1;
          start_rs_s = 1'b1;
          start_db_s = col_byte(shadow2_r, 4'd0);
        end else begin
          state_s = ST_ADDR2;
        end
      end
      ST_DATA2: begin
        if (byte_done_s) begin
          if (col_r == 4'd15) begin
            state_s      = ST_GAP;
            col_s        = 4'd0;
            cnt_s        = FRAME_GAP_M1;
            frame_done_s = 1'b1;
          end else begin
            col_s      = col_r + 4'd1;
            start_s    = 1'b1;
            start_rs_s = 1'b1;
            start_db_s = col_byte(shadow2_r, col_r + 4'd1);
          end
        end else begin
          state_s = ST_DATA2;
        end
      end
      ST_GAP: begin
        // freeze_in only matters once the gap has fully elapsed.
        if (cnt_r == 24'd0) begin
          if (freeze_in) begin
            state_s = ST_GAP;
          end else begin
            state_s = ST_SNAP;
          end
        end else begin
          cnt_s = cnt_r - 24'd1;
        end
      end
      default: begin
        state_s = ST_PWR;
        cnt_s   = PWR_WAIT_M1;
      end
    endcase

    // rs/db are only ever updated on entry to SETUP, so they are stable
    // through the strobe and the hold time.
    if (start_s) begin
      bw_s = BW_SETUP;
      rs_s = start_rs_s;
      db_s = start_db_s;
    end else begin
      rs_s = rs_r;
      db_s = db_r;
    end

    e_s = (bw_s == BW_EHI);
  end

  // State, counter, registered LCD outputs and row shadows.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r      <= ST_PWR;
      bw_r         <= BW_IDLE;
      cnt_r        <= PWR_WAIT_M1;
      idx_r        <= 3'd0;
      col_r        <= 4'd0;
      rs_r         <= 1'b0;
      db_r         <= 8'h00;
      e_r          <= 1'b0;
      init_done_r  <= 1'b0;
      frame_done_r <= 1'b0;
      shadow1_r    <= {16{8'h20}};
      shadow2_r    <= {16{8'h20}};
    end else begin
      state_r      <= state_s;
      bw_r         <= bw_s;
      cnt_r        <= cnt_s;
      idx_r        <= idx_s;
      col_r        <= col_s;
      rs_r         <= rs_s;
      db_r         <= db_s;
      e_r          <= e_s;
      init_done_r  <= init_done_s;
      frame_done_r <= frame_done_s;
      if (snap_s) begin
        shadow1_r <= line1_in;
        shadow2_r <= line2_in;
      end else begin
        shadow1_r <= shadow1_r;
        shadow2_r <= shadow2_r;
      end
    end
  end

  assign lcd_rs_out     = rs_r;
  assign lcd_rw_out     = 1'b0;
  assign lcd_e_out      = e_r;
  assign lcd_db_out     = db_r;
  assign init_done_out  = init_done_r;
  assign frame_done_out = frame_done_r;

endmodule

// File: doc/lcd_refresh_ctrl.md
# lcd_refresh_ctrl

Sequencer that drives a 16x2 HD44780-compatible character LCD in 8-bit write-only mode from the two 128-bit line buffers produced by the game engine. After reset it runs the power-up wait and the LCD initialisation command sequence. It then refreshes the display continuously: it snapshots both lines, writes them to DDRAM, idles for a programmable gap, and repeats.

## Interface
- E_HIGH, 12: cycles lcd_e_out is held high per byte (12 cycles is 240 ns at 50 MHz).
- CMD_GAP, 2500: wait cycles after each command or data byte except clear.
- CLEAR_GAP, 100000: wait cycles after the clear-display command (0x01).
- PWR_WAIT, 1000000: power-up wait cycles before the first command.
- FRAME_GAP, 50000: idle cycles between the end of one frame and the next snapshot.
- All parameters are at least 1 and below 2^24; one shared 24-bit down-counter serves every wait.

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: reset, synchronous, active-high.
- line1_in, input, 128: top row; bits [127:120] are column 0 (leftmost), bits [7:0] are column 15.
- line2_in, input, 128: bottom row, same byte order as line1_in.
- freeze_in, input, 1: when high, no new frame starts; the display keeps its last content.
- lcd_rs_out, output, 1: 0 = command, 1 = data.
- lcd_rw_out, output, 1: tied 0 (write only).
- lcd_e_out, output, 1: enable strobe.
- lcd_db_out, output, 8: data bus.
- init_done_out, output, 1: goes high after the clear-command gap completes; stays high until reset.
- frame_done_out, output, 1: one-cycle pulse at the end of every complete frame.

## Operation
- Top FSM: PWR → INIT → SNAP → ADDR1 → DATA1 → ADDR2 → DATA2 → GAP → SNAP …
- PWR: count PWR_WAIT cycles with all LCD outputs at their reset values.
- INIT: send commands 0x38, 0x38, 0x38, 0x0C, 0x06, 0x01, in that order, with rs=0. A 3-bit index steps through the list.
- SNAP: one cycle. Register line1_in and line2_in into shadow registers. Data bytes come only from the shadow registers, so the display never tears when the inputs change mid-frame.
- ADDR1: send 0x80 (rs=0).
- DATA1: send 16 bytes from shadow line 1, column 0 to 15 (rs=1). A 4-bit column counter wraps 15→0 and advances the FSM.
- ADDR2: send 0xC0 (rs=0).
- DATA2: send 16 bytes from shadow line 2, same order (rs=1).
- Byte writer sub-FSM, used for every byte:
  - SETUP, 1 cycle: rs and db driven, e=0.
  - EHI, E_HIGH cycles: e=1.
  - HOLD, GAP cycles: e=0, rs and db held. GAP is CLEAR_GAP for the 0x01 command and CMD_GAP for everything else.
  - It then returns "byte done" to the top FSM.
- frame_done_out pulses in the cycle the last DATA2 byte's HOLD ends. The FSM then enters GAP.
- GAP: count FRAME_GAP cycles, then go to SNAP. If freeze_in is high when the count expires, stay in GAP until freeze_in is low, then go to SNAP on the next cycle.
- freeze_in is sampled only at the end of GAP. A frame in progress always completes.

## Timing
- Reset values: lcd_rs_out=0, lcd_rw_out=0, lcd_e_out=0, lcd_db_out=0x00, init_done_out=0, frame_done_out=0. Shadow registers reset to 0x20 (spaces). FSM resets to PWR with the counter loaded.
- Reset asserted mid-byte or mid-frame: all outputs return to their reset values on the next edge. The full PWR plus INIT sequence reruns after release; no partial frame resumes.
- Cycles per byte: 1+E_HIGH+CMD_GAP, or 1+E_HIGH+CLEAR_GAP for the clear command.
- Frame period, from SNAP to the next SNAP with freeze_in low: 1 + 34·(1+E_HIGH+CMD_GAP) + FRAME_GAP.
- The first lcd_e_out rise occurs PWR_WAIT+1 cycles after the first clock edge with rst_in low.
- lcd_db_out and lcd_rs_out change only in SETUP cycles, never while e=1 or during HOLD.

## Test plan
- Timing parameters for tests: E_HIGH=2, CMD_GAP=4, CLEAR_GAP=8, PWR_WAIT=10, FRAME_GAP=5.
- Init sequence: release reset → first e rise at cycle 11. The e-high windows carry db=38,38,38,0C,06,01 with rs=0, each window 2 cycles. init_done_out rises 11 cycles after the 0x01 SETUP cycle begins.
- Frame content: line1_in = "  Game  Over    " and line2_in = all 0x3E → after 0x80 the bench sees the 16 bytes 20 20 47 61 6D 65 20 20 4F 76 65 72 20 20 20 20 with rs=1. After 0xC0 it sees sixteen 0x3E bytes. frame_done_out is high for exactly 1 cycle.
- Frame period: consecutive frame_done_out pulses are 244 cycles apart.
- Snapshot isolation: change line1_in to all 0x41 during DATA1 → the rest of the current frame shows the old bytes. The next frame is all 0x41.
- Freeze: hold freeze_in high across GAP → no e pulse while it is high. SNAP occurs 1 cycle after freeze_in drops, and the first e rise follows 2 cycles after that.
- Mid-frame reset: assert rst_in for 1 cycle during an EHI of DATA2 → e is low on the next edge and init_done_out=0. The bench sees the full init sequence again, with the first e rise 11 cycles after release.
